// File: rtl/dac_serial_if.sv
// dac_serial_if: serialises 8-bit samples onto a 3-wire DAC link (CS_n/SCLK/DIN)
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   sample_in         unsigned sample from the modulation stage
//   sample_valid      one-cycle strobe qualifying sample_in
//   dac_cs_n          DAC chip select, active low
//   dac_sclk          DAC serial clock, idle low, DAC samples on rising edge
//   dac_din           DAC serial data, MSB first, 0 while deselected
//   busy              frame or inter-frame gap in progress
//   frame_done        one-cycle pulse coincident with CS_n rising
//   overrun_cnt       saturating count of pending samples overwritten unsent
module dac_serial_if #(
    parameter int HALF_DIV   = 2,
    parameter int FRAME_BITS = 12,
    parameter int CS_GAP     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sample_in,
    input  logic       sample_valid,
    output logic       dac_cs_n,
    output logic       dac_sclk,
    output logic       dac_din,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] overrun_cnt
);
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
    state_t                state, state_d;
    logic [7:0]            pend, pend_d;
    logic                  pend_v, pend_v_d;
    logic [FRAME_BITS-1:0] sreg, sreg_d;
    logic [7:0]            cnt, cnt_d;
    logic [4:0]            bit_cnt, bit_d;
    logic                  cs_n_d, sclk_d, din_d, busy_d, done_d;
    logic [7:0]            ovr_d;
    logic                  consume;
    assign consume = (state == IDLE) && pend_v;
    always_comb begin
        state_d  = state;
        sreg_d   = sreg;
        cnt_d    = cnt;
        bit_d    = bit_cnt;
        cs_n_d   = dac_cs_n;
        sclk_d   = dac_sclk;
        din_d    = dac_din;
        busy_d   = busy;
        done_d   = 1'b0;
        pend_d   = pend;
        pend_v_d = pend_v;
        ovr_d    = overrun_cnt;
        case (state)
            IDLE: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b0;
                din_d  = 1'b0;
                busy_d = 1'b0;
                if (pend_v) begin
                    // sample left-aligned in the frame, trailing bits zero
                    sreg_d  = FRAME_BITS'({pend, 8'h00} >> (16 - FRAME_BITS));
                    din_d   = pend[7];
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = 8'd0;
                    bit_d   = 5'd0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == 8'(HALF_DIV - 1)) begin
                    cnt_d = 8'd0;
                    if (!dac_sclk) begin
                        sclk_d = 1'b1;
                    end else if (bit_cnt == 5'(FRAME_BITS - 1)) begin
                        sclk_d  = 1'b0;
                        cs_n_d  = 1'b1;
                        din_d   = 1'b0;
                        done_d  = 1'b1;
                        state_d = GAP;
                    end else begin
                        // din advances only with the falling sclk edge
                        sclk_d = 1'b0;
                        bit_d  = bit_cnt + 5'd1;
                        sreg_d = sreg << 1;
                        din_d  = sreg[FRAME_BITS-2];
                    end
                end else begin
                    cnt_d = cnt + 8'd1;
                end
            end
            GAP: begin
                if (cnt == 8'(CS_GAP - 1)) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // a strobe coinciding with IDLE's consume refills pending without overrun
        if (sample_valid) begin
            pend_d   = sample_in;
            pend_v_d = 1'b1;
            if (pend_v && !consume && overrun_cnt != 8'hFF) ovr_d = overrun_cnt + 8'd1;
        end else if (consume) begin
            pend_v_d = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pend        <= 8'd0;
            pend_v      <= 1'b0;
            sreg        <= '0;
            cnt         <= 8'd0;
            bit_cnt     <= 5'd0;
            dac_cs_n    <= 1'b1;
            dac_sclk    <= 1'b0;
            dac_din     <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            overrun_cnt <= 8'd0;
        end else begin
            state       <= state_d;
            pend        <= pend_d;
            pend_v      <= pend_v_d;
            sreg        <= sreg_d;
            cnt         <= cnt_d;
            bit_cnt     <= bit_d;
            dac_cs_n    <= cs_n_d;
            dac_sclk    <= sclk_d;
            dac_din     <= din_d;
            busy        <= busy_d;
            frame_done  <= done_d;
            overrun_cnt <= ovr_d;
        end
    end
endmodule

// File: tb/tb_dac_serial_if.sv
// tb_dac_serial_if: scoreboard bench for dac_serial_if (default and HALF_DIV=1/FRAME_BITS=16 builds)
module tb_dac_serial_if;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sample_in = 8'd0;
    logic       sv_a = 1'b0, sv_b = 1'b0;
    logic       cs_a, sclk_a, din_a, busy_a, fd_a;
    logic       cs_b, sclk_b, din_b, busy_b, fd_b;
    logic [7:0] ovr_a, ovr_b;
    logic       sel = 1'b0;

    always #5 clk = ~clk;

    dac_serial_if dut_a (
        .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sv_a),
        .dac_cs_n(cs_a), .dac_sclk(sclk_a), .dac_din(din_a), .busy(busy_a),
        .frame_done(fd_a), .overrun_cnt(ovr_a)
    );

    dac_serial_if #(.HALF_DIV(1), .FRAME_BITS(16), .CS_GAP(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sv_b),
        .dac_cs_n(cs_b), .dac_sclk(sclk_b), .dac_din(din_b), .busy(busy_b),
        .frame_done(fd_b), .overrun_cnt(ovr_b)
    );

    typedef struct {
        logic [15:0] word;
        int          len;
        int          nb;
        int          gap;
    } frame_t;

    frame_t      got_q[$];
    logic [15:0] exp_q[$];
    int          passed = 0, total = 0;
    int          fd_cnt = 0, fd_err = 0, tog_err = 0, idle_err = 0;

    logic        m_cs, m_sclk, m_din, m_fd;
    assign m_cs   = sel ? cs_b   : cs_a;
    assign m_sclk = sel ? sclk_b : sclk_a;
    assign m_din  = sel ? din_b  : din_a;
    assign m_fd   = sel ? fd_b   : fd_a;

    // DAC-side monitor: captures din on each sclk rising edge while selected
    logic        p_cs = 1'b1, p_sclk = 1'b0;
    int          len = 0, nb = 0, high = 0, last_high = 0;
    logic [15:0] word = 16'd0;
    initial forever begin
        @(negedge clk);
        if (!m_cs) begin
            if (p_cs) begin
                len = 0; nb = 0; word = 16'd0; last_high = high;
            end
            if (sel && m_sclk !== len[0]) tog_err++;
            len++;
            if (m_sclk && !p_sclk) begin
                word = {word[14:0], m_din};
                nb++;
            end
        end else begin
            if (!p_cs) begin
                got_q.push_back('{word, len, nb, last_high});
                high = 0;
            end
            high++;
            if (m_sclk !== 1'b0 || m_din !== 1'b0) idle_err++;
        end
        if (m_fd === 1'b1 && !(m_cs && !p_cs)) fd_err++;
        if (m_fd === 1'b1) fd_cnt++;
        p_cs = m_cs;
        p_sclk = m_sclk;
    end

    task automatic apply_reset();
        rst_n = 1'b0; sv_a = 1'b0; sv_b = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        got_q.delete(); exp_q.delete();
        fd_cnt = 0; fd_err = 0; tog_err = 0; idle_err = 0;
    endtask

    task automatic strobe(input logic [7:0] v, input bit expect_tx);
        @(posedge clk); #1;
        sample_in = v;
        if (sel) sv_b = 1'b1; else sv_a = 1'b1;
        if (expect_tx) exp_q.push_back(sel ? {v, 8'h00} : {4'h0, v, 4'h0});
        @(posedge clk); #1;
        sv_a = 1'b0; sv_b = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk); #1;
            ok = (got_q.size() >= n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (cs_a !== 1'b1) $display("FAIL reset_cs_n: got %b want 1", cs_a); else passed++;
        total++; if (sclk_a !== 1'b0) $display("FAIL reset_sclk: got %b want 0", sclk_a); else passed++;
        total++; if (din_a !== 1'b0) $display("FAIL reset_din: got %b want 0", din_a); else passed++;
        total++; if (busy_a !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_a); else passed++;
        total++; if (fd_a !== 1'b0) $display("FAIL reset_frame_done: got %b want 0", fd_a); else passed++;
        total++; if (ovr_a !== 8'd0) $display("FAIL reset_overrun: got %0d want 0", ovr_a); else passed++;
        apply_reset();
        repeat (10) @(negedge clk);
        total++; if (got_q.size() != 0) $display("FAIL reset_no_frame: got %0d frames want 0", got_q.size()); else passed++;
    endtask

    task automatic test_single();
        bit ok;
        frame_t f;
        logic [15:0] e;
        apply_reset();
        strobe(8'hA5, 1'b1);
        total++; if (cs_a !== 1'b1) $display("FAIL single_cs_early: got %b want 1", cs_a); else passed++;
        @(posedge clk); #1;
        total++; if (cs_a !== 1'b0) $display("FAIL single_latency: cs_n got %b want 0", cs_a); else passed++;
        total++; if (din_a !== 1'b1) $display("FAIL single_first_din: got %b want 1", din_a); else passed++;
        total++; if (busy_a !== 1'b1) $display("FAIL single_busy: got %b want 1", busy_a); else passed++;
        wait_frames(1, 200, ok);
        total++; if (!ok) $display("FAIL single_timeout: got %0d frames want 1", got_q.size()); else passed++;
        if (ok) begin
            f = got_q.pop_front();
            e = exp_q.pop_front();
            total++; if (f.word !== e) $display("FAIL single_data: got %h want %h", f.word, e); else passed++;
            total++; if (f.len != 48) $display("FAIL single_cs_low: got %0d want 48", f.len); else passed++;
            total++; if (f.nb != 12) $display("FAIL single_bits: got %0d want 12", f.nb); else passed++;
        end
        repeat (10) @(negedge clk);
        total++; if (fd_cnt != 1) $display("FAIL single_done_count: got %0d want 1", fd_cnt); else passed++;
        total++; if (fd_err != 0) $display("FAIL single_done_align: got %0d stray want 0", fd_err); else passed++;
        total++; if (ovr_a !== 8'd0) $display("FAIL single_overrun: got %0d want 0", ovr_a); else passed++;
        total++; if (idle_err != 0) $display("FAIL single_idle_lines: got %0d errors want 0", idle_err); else passed++;
        total++; if (busy_a !== 1'b0) $display("FAIL single_busy_end: got %b want 0", busy_a); else passed++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        frame_t f;
        logic [15:0] e;
        apply_reset();
        strobe(8'h3C, 1'b1);
        repeat (8) @(posedge clk);
        strobe(8'hFF, 1'b1);
        wait_frames(2, 300, ok);
        total++; if (!ok) $display("FAIL b2b_timeout: got %0d frames want 2", got_q.size()); else passed++;
        for (int i = 0; ok && i < 2; i++) begin
            f = got_q.pop_front();
            e = exp_q.pop_front();
            total++; if (f.word !== e) $display("FAIL b2b_data%0d: got %h want %h", i, f.word, e); else passed++;
            total++; if (f.len != 48) $display("FAIL b2b_cs_low%0d: got %0d want 48", i, f.len); else passed++;
            if (i == 1) begin
                total++; if (f.gap != 5) $display("FAIL b2b_gap: got %0d want 5", f.gap); else passed++;
            end
        end
        total++; if (ovr_a !== 8'd0) $display("FAIL b2b_overrun: got %0d want 0", ovr_a); else passed++;
    endtask

    task automatic test_overrun();
        bit ok;
        frame_t f;
        logic [15:0] e;
        apply_reset();
        strobe(8'h11, 1'b1);
        repeat (3) @(posedge clk);
        strobe(8'h22, 1'b0);
        repeat (3) @(posedge clk);
        strobe(8'h33, 1'b1);
        wait_frames(2, 300, ok);
        total++; if (!ok) $display("FAIL ovr_timeout: got %0d frames want 2", got_q.size()); else passed++;
        for (int i = 0; ok && i < 2; i++) begin
            f = got_q.pop_front();
            e = exp_q.pop_front();
            total++; if (f.word !== e) $display("FAIL ovr_data%0d: got %h want %h", i, f.word, e); else passed++;
        end
        total++; if (ovr_a !== 8'd1) $display("FAIL ovr_count: got %0d want 1", ovr_a); else passed++;
        repeat (80) @(negedge clk);
        total++; if (got_q.size() != 0) $display("FAIL ovr_extra_frame: got %0d want 0", got_q.size()); else passed++;
    endtask

    task automatic test_saturate();
        frame_t f;
        int bad_len, bad_gap, n;
        apply_reset();
        for (int i = 0; i < 300; i++) strobe(8'(i), 1'b0);
        total++; if (ovr_a !== 8'd255) $display("FAIL sat_count: got %0d want 255", ovr_a); else passed++;
        repeat (120) @(negedge clk);
        bad_len = 0; bad_gap = 0; n = got_q.size();
        for (int i = 0; i < n; i++) begin
            f = got_q.pop_front();
            if (f.len != 48 || f.nb != 12) bad_len++;
            if (i > 0 && f.gap < 5) bad_gap++;
        end
        total++; if (n < 11) $display("FAIL sat_frames: got %0d want >=11", n); else passed++;
        total++; if (bad_len != 0) $display("FAIL sat_len: got %0d bad frames want 0", bad_len); else passed++;
        total++; if (bad_gap != 0) $display("FAIL sat_gap: got %0d short gaps want 0", bad_gap); else passed++;
        total++; if (ovr_a !== 8'd255) $display("FAIL sat_nowrap: got %0d want 255", ovr_a); else passed++;
    endtask

    task automatic test_reset_midframe();
        bit seen;
        apply_reset();
        strobe(8'h5A, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            seen = (cs_a == 1'b0);
        end
        total++; if (!seen) $display("FAIL rst_frame_start: cs_n got %b want 0", cs_a); else passed++;
        strobe(8'h77, 1'b0);
        repeat (16) @(posedge clk);
        #2;
        total++; if (cs_a !== 1'b0) $display("FAIL rst_in_frame: cs_n got %b want 0", cs_a); else passed++;
        rst_n = 1'b0;
        #1;
        total++; if (cs_a !== 1'b1) $display("FAIL rst_async_cs: got %b want 1", cs_a); else passed++;
        total++; if (sclk_a !== 1'b0) $display("FAIL rst_async_sclk: got %b want 0", sclk_a); else passed++;
        total++; if (din_a !== 1'b0) $display("FAIL rst_async_din: got %b want 0", din_a); else passed++;
        total++; if (busy_a !== 1'b0) $display("FAIL rst_async_busy: got %b want 0", busy_a); else passed++;
        repeat (3) @(negedge clk);
        got_q.delete(); exp_q.delete();
        #1 rst_n = 1'b1;
        repeat (150) @(negedge clk);
        total++; if (got_q.size() != 0) $display("FAIL rst_no_restart: got %0d frames want 0", got_q.size()); else passed++;
        total++; if (cs_a !== 1'b1) $display("FAIL rst_idle_cs: got %b want 1", cs_a); else passed++;
    endtask

    task automatic test_wide_frame();
        bit ok;
        frame_t f;
        logic [15:0] e;
        sel = 1'b1;
        apply_reset();
        strobe(8'h80, 1'b1);
        wait_frames(1, 200, ok);
        total++; if (!ok) $display("FAIL wide_timeout: got %0d frames want 1", got_q.size()); else passed++;
        if (ok) begin
            f = got_q.pop_front();
            e = exp_q.pop_front();
            total++; if (f.word !== e) $display("FAIL wide_data: got %h want %h", f.word, e); else passed++;
            total++; if (f.len != 32) $display("FAIL wide_cs_low: got %0d want 32", f.len); else passed++;
            total++; if (f.nb != 16) $display("FAIL wide_bits: got %0d want 16", f.nb); else passed++;
        end
        repeat (10) @(negedge clk);
        total++; if (tog_err != 0) $display("FAIL wide_sclk_toggle: got %0d errors want 0", tog_err); else passed++;
        total++; if (fd_cnt != 1) $display("FAIL wide_done_count: got %0d want 1", fd_cnt); else passed++;
        total++; if (ovr_b !== 8'd0) $display("FAIL wide_overrun: got %0d want 0", ovr_b); else passed++;
        total++; if (busy_b !== 1'b0) $display("FAIL wide_busy_end: got %b want 0", busy_b); else passed++;
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_saturate();
        test_reset_midframe();
        test_wide_frame();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
